// File: rtl/lab2_proc_fetch_pkg.sv
// Shared fetch-side types: instruction word, imem response message, count-width helper.
package lab2_proc_fetch_pkg;

  typedef logic [31:0] inst_t;

  localparam inst_t c_fetch_reset_inst = 32'h0;

  typedef struct packed {
    logic [2:0] msg_type;
    logic [7:0] opaque;
    logic [1:0] test;
    logic [1:0] len;
    inst_t      data;
  } mem_resp_4B_t;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lab2_proc_imem_resp_queue.sv
// Circular instruction buffer of arbitrary depth; pointers wrap at p_num_entries.
module lab2_proc_imem_resp_queue
  import lab2_proc_fetch_pkg::*;
#(
  parameter int unsigned p_num_entries = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    enq_val,
  input  inst_t                                   enq_data,
  input  logic                                    deq,
  output inst_t                                   head,
  output logic [cnt_width(p_num_entries)-1:0]     count,
  output logic                                    full,
  output logic                                    empty
);

  localparam int unsigned PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int unsigned CW = cnt_width(p_num_entries);
  localparam logic [PW-1:0] LastPtr = PW'(p_num_entries - 1);

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  inst_t         mem_q [p_num_entries];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_val) tail_q <= bump(tail_q);
      if (deq)     head_q <= bump(head_q);
      count_q <= count_q + CW'(enq_val) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_val) mem_q[tail_q] <= enq_data;
  end

  assign head  = mem_q[head_q];
  assign count = count_q;
  assign full  = (count_q == CW'(p_num_entries));
  assign empty = (count_q == '0);

endmodule

// File: rtl/lab2_proc_imem_resp_drop_queue.sv
// Imem response queue with credit throttling and squash (drop) handling.
// Optional drop statistics counter enabled by defining PROC_IMEM_DROP_STATS_EN.
module lab2_proc_imem_resp_drop_queue
  import lab2_proc_fetch_pkg::*;
#(
  parameter int unsigned p_num_entries = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_fire,
  output logic         req_stall,
  input  logic         resp_val,
  output logic         resp_rdy,
  input  mem_resp_4B_t resp_msg,
  input  logic         drop,
  output logic         inst_val,
  input  logic         inst_rdy,
  output inst_t        inst_data
`ifdef PROC_IMEM_DROP_STATS_EN
  , output logic [31:0] drop_count
`endif
);

  localparam int unsigned CW = cnt_width(p_num_entries);
  localparam logic [CW-1:0] NumEntries = CW'(p_num_entries);

  logic [CW-1:0] n_if_q, n_if_d, n_drop_q, n_drop_d, n_q;
  logic [CW-1:0] n_if_after, n_drop_after;
  logic          q_full, q_empty, q_enq, q_deq;
  inst_t         q_head;
  logic          resp_fire, resp_discard, resp_keep;
  logic          drop_head, drop_resp, drop_future, bypass;

  // Only .data is consumed; the remaining fields are intentionally ignored.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{resp_msg.msg_type, resp_msg.opaque, resp_msg.test, resp_msg.len};

  lab2_proc_imem_resp_queue #(
    .p_num_entries (p_num_entries)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (q_enq),
    .enq_data (resp_msg.data),
    .deq      (q_deq),
    .head     (q_head),
    .count    (n_q),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_comb begin
    req_stall = ({1'b0, n_if_q} + {1'b0, n_q}) >= {1'b0, NumEntries};
    resp_rdy  = !q_full;
    // A response with nothing in flight (e.g. stale after reset) is swallowed.
    resp_fire    = resp_val && resp_rdy && (n_if_q != '0);
    resp_discard = resp_fire && (n_drop_q != '0);
    resp_keep    = resp_fire && !resp_discard;

    n_if_after   = n_if_q - CW'(resp_fire);
    n_drop_after = n_drop_q - CW'(resp_discard);

    drop_head   = drop && !q_empty;
    drop_resp   = drop && q_empty && resp_keep;
    drop_future = drop && q_empty && !resp_keep && (n_if_after > n_drop_after);

    inst_val  = (!q_empty || resp_keep) && !drop;
    inst_data = !q_empty ? q_head : (resp_keep ? resp_msg.data : c_fetch_reset_inst);

    bypass = q_empty && resp_keep && !drop && inst_rdy;
    q_enq  = resp_keep && !drop_resp && !bypass;
    q_deq  = drop_head || (!q_empty && inst_val && inst_rdy);

    n_if_d   = n_if_after + CW'(req_fire);
    n_drop_d = n_drop_after + CW'(drop_future);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_if_q   <= '0;
      n_drop_q <= '0;
    end else begin
      n_if_q   <= n_if_d;
      n_drop_q <= n_drop_d;
    end
  end

`ifdef PROC_IMEM_DROP_STATS_EN
  logic [31:0] drop_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_q + 32'(drop_head) + 32'(drop_resp) + 32'(resp_discard);
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_lab2_proc_imem_resp_drop_queue.sv
// Directed bench for lab2_proc_imem_resp_drop_queue with a queue-level reference model.
module tb_lab2_proc_imem_resp_drop_queue;
  import lab2_proc_fetch_pkg::*;

  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_fire = 1'b0;
  logic         req_stall;
  logic         resp_val = 1'b0;
  logic         resp_rdy;
  mem_resp_4B_t resp_msg = '0;
  logic         drop = 1'b0;
  logic         inst_val;
  logic         inst_rdy = 1'b0;
  inst_t        inst_data;
`ifdef PROC_IMEM_DROP_STATS_EN
  logic [31:0]  drop_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  lab2_proc_imem_resp_drop_queue #(
    .p_num_entries (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_fire  (req_fire),
    .req_stall (req_stall),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_msg  (resp_msg),
    .drop      (drop),
    .inst_val  (inst_val),
    .inst_rdy  (inst_rdy),
    .inst_data (inst_data)
`ifdef PROC_IMEM_DROP_STATS_EN
    , .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of undelivered buffered words plus in-flight bookkeeping.
  inst_t       mq[$];
  int          m_if = 0;
  int          m_drop = 0;
  logic [31:0] m_cnt = '0;
  bit          full, valid, disc, keep, had_q, e_val, e_stall;
  inst_t       e_data;
  int          remaining;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_if = 0;
      m_drop = 0;
      m_cnt = '0;
      check32("rst_req_stall", 32'(req_stall), 32'd0);
      check32("rst_resp_rdy", 32'(resp_rdy), 32'd1);
      check32("rst_inst_val", 32'(inst_val), 32'd0);
      check32("rst_inst_data", inst_data, 32'h0);
`ifdef PROC_IMEM_DROP_STATS_EN
      check32("rst_drop_count", drop_count, 32'd0);
`endif
    end else begin
      full    = (mq.size() >= P);
      valid   = resp_val && !full && (m_if > 0);
      disc    = valid && (m_drop > 0);
      keep    = valid && !disc;
      had_q   = (mq.size() > 0);
      e_val   = (had_q || keep) && !drop;
      e_data  = had_q ? mq[0] : resp_msg.data;
      e_stall = (m_if + mq.size()) >= P;
      check32("req_stall", 32'(req_stall), 32'(e_stall));
      check32("resp_rdy", 32'(resp_rdy), 32'(!full));
      check32("inst_val", 32'(inst_val), 32'(e_val));
      if (e_val) check32("inst_data", inst_data, e_data);
`ifdef PROC_IMEM_DROP_STATS_EN
      check32("drop_count", drop_count, m_cnt);
`endif
      // Advance the model.
      if (keep) mq.push_back(resp_msg.data);
      if (disc) begin
        m_drop--;
        m_cnt++;
      end
      remaining = m_if - (valid ? 1 : 0);
      m_if = remaining + (req_fire ? 1 : 0);
      if (drop) begin
        if (had_q) begin
          void'(mq.pop_front());
          m_cnt++;
        end else if (keep) begin
          void'(mq.pop_back());
          m_cnt++;
        end else if (remaining > m_drop) begin
          m_drop++;
        end
      end else if (e_val && inst_rdy) begin
        void'(mq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rf, input logic rv, input logic [31:0] d,
                        input logic dr, input logic ir);
    req_fire      = rf;
    resp_val      = rv;
    resp_msg      = '0;
    resp_msg.data = d;
    drop          = dr;
    inst_rdy      = ir;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // In-order, zero-latency bypass.
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    set_in(1'b0, 1'b1, 32'h13, 1'b0, 1'b1); #2;
    check32("t1_stall_full_credit", 32'(req_stall), 32'd1);
    check32("t1_val0", 32'(inst_val), 32'd1);
    check32("t1_data0", inst_data, 32'h13);
    tick();
    set_in(1'b0, 1'b1, 32'h93, 1'b0, 1'b1); #2;
    check32("t1_val1", 32'(inst_val), 32'd1);
    check32("t1_data1", inst_data, 32'h93);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); #2;
    check32("t1_idle_val", 32'(inst_val), 32'd0);
    check32("t1_idle_stall", 32'(req_stall), 32'd0);
    tick();

    // Credit: fill the queue with inst_rdy low.
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 32'h11, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 32'h22, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); #2;
    check32("t2_full_stall", 32'(req_stall), 32'd1);
    check32("t2_full_resp_rdy", 32'(resp_rdy), 32'd0);
    check32("t2_head0", inst_data, 32'h11);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); #2;
    check32("t2_stall_released", 32'(req_stall), 32'd0);
    check32("t2_head1", inst_data, 32'h22);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); tick();

    // Drop while both requests are still in flight.
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    set_in(1'b0, 1'b1, 32'hA, 1'b0, 1'b1); #2;
    check32("t3_a_discarded", 32'(inst_val), 32'd0);
    tick();
    set_in(1'b0, 1'b1, 32'hB, 1'b0, 1'b1); #2;
    check32("t3_b_val", 32'(inst_val), 32'd1);
    check32("t3_b_data", inst_data, 32'hB);
    tick();
`ifdef PROC_IMEM_DROP_STATS_EN
    check32("t3_drop_count", drop_count, 32'd1);
`endif

    // Drop a buffered head.
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 32'h41, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 32'h42, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); #2;
    check32("t4_drop_val", 32'(inst_val), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); #2;
    check32("t4_b_val", 32'(inst_val), 32'd1);
    check32("t4_b_data", inst_data, 32'h42);
    tick();
`ifdef PROC_IMEM_DROP_STATS_EN
    check32("t4_drop_count", drop_count, 32'd2);
`endif

    // Drop coincident with a response into an empty queue.
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    set_in(1'b0, 1'b1, 32'hC3, 1'b1, 1'b1); #2;
    check32("t5_val", 32'(inst_val), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); #2;
    check32("t5_n_if_cleared", 32'(req_stall), 32'd0);
    check32("t5_idle_val", 32'(inst_val), 32'd0);
    tick();
`ifdef PROC_IMEM_DROP_STATS_EN
    check32("t5_drop_count", drop_count, 32'd3);
`endif

    // Pointer wrap through repeated single-entry traffic.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
      set_in(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0); tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); #2;
      check32("wrap_data", inst_data, 32'h100 + 32'(i));
      tick();
    end

    // Reset mid-operation with a full queue and a request in flight.
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 32'h61, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 32'h62, 1'b0, 1'b0); tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    check32("t6_rst_val", 32'(inst_val), 32'd0);
    check32("t6_rst_stall", 32'(req_stall), 32'd0);
    check32("t6_rst_resp_rdy", 32'(resp_rdy), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    set_in(1'b0, 1'b1, 32'hBAD, 1'b0, 1'b1); #2;
    check32("t6_stray_ignored", 32'(inst_val), 32'd0);
    tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b1); tick();
    set_in(1'b0, 1'b1, 32'h55, 1'b0, 1'b1); #2;
    check32("t6_post_val", 32'(inst_val), 32'd1);
    check32("t6_post_data", inst_data, 32'h55);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
